// File: rtl/paddle_input_ctrl.sv
// Paddle input stage: synchronises and debounces the buttons, then steps the paddle once per tick.
// Define PADDLE_ACCEL_EN to enable hold-to-accelerate (step 1 -> 2 -> 4); otherwise step is 1.
module paddle_input_ctrl #(
  parameter int unsigned POS_W       = 9,
  parameter int unsigned POS_MAX     = 511,
  parameter int unsigned POS_INIT    = 256,
  parameter int unsigned DEB_CYCLES  = 250000,
  parameter int unsigned TICK_CYCLES = 50000,
  parameter int unsigned ACCEL_HOLD  = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left_raw,
  input  logic             right_raw,
  output logic [POS_W-1:0] paddle_pos,
  output logic             pos_update,
  output logic             left_db,
  output logic             right_db
);

  localparam int unsigned DebW  = $clog2(DEB_CYCLES + 1);
  localparam int unsigned TickW = $clog2(TICK_CYCLES + 1);

  localparam logic [DebW-1:0]  DebLast   = DebW'(DEB_CYCLES - 1);
  localparam logic [TickW-1:0] TickLast  = TickW'(TICK_CYCLES - 1);
  localparam logic [POS_W:0]   PosMaxExt = (POS_W + 1)'(POS_MAX);

  if (POS_MAX >= (1 << POS_W) || DEB_CYCLES == 0 || TICK_CYCLES == 0 || ACCEL_HOLD == 0)
  begin : gBadParams
    $error("paddle_input_ctrl: invalid parameter set");
  end

  typedef enum logic [1:0] {
    StIdle,
    StMoveR,
    StMoveL
  } state_e;

  // Index 0 is the left button, index 1 the right button.
  logic [1:0]      syncMeta;
  logic [1:0]      syncLvl;
  logic [1:0]      dbLvl;
  logic [DebW-1:0] debCnt [2];

  logic [TickW-1:0] tickCnt;
  logic             tick;

  state_e           stateQ;
  state_e           stateNext;
  logic [2:0]       step;
  logic [POS_W:0]   posExt;
  logic [POS_W:0]   stepExt;
  logic [POS_W:0]   sumR;
  logic [POS_W:0]   diffL;
  logic [POS_W-1:0] newR;
  logic [POS_W-1:0] newL;
  logic [POS_W-1:0] posNew;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncMeta <= 2'b00;
      syncLvl  <= 2'b00;
    end else begin
      syncMeta <= {right_raw, left_raw};
      syncLvl  <= syncMeta;
    end
  end

  // The counter only runs while the synchronised level disagrees with the debounced one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbLvl <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        debCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (syncLvl[i] == dbLvl[i]) begin
          debCnt[i] <= '0;
        end else if (debCnt[i] == DebLast) begin
          dbLvl[i]  <= syncLvl[i];
          debCnt[i] <= '0;
        end else begin
          debCnt[i] <= debCnt[i] + 1'b1;
        end
      end
    end
  end

  assign left_db  = dbLvl[0];
  assign right_db = dbLvl[1];

  assign tick = (tickCnt == TickLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tickCnt <= '0;
    end else if (tick) begin
      tickCnt <= '0;
    end else begin
      tickCnt <= tickCnt + 1'b1;
    end
  end

  // Right always wins when held, whatever the current state.
  always_comb begin
    stateNext = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (dbLvl[1]) begin
          stateNext = StMoveR;
        end else if (dbLvl[0]) begin
          stateNext = StMoveL;
        end
      end
      StMoveR: begin
        if (!dbLvl[1]) begin
          stateNext = dbLvl[0] ? StMoveL : StIdle;
        end
      end
      StMoveL: begin
        if (dbLvl[1]) begin
          stateNext = StMoveR;
        end else if (!dbLvl[0]) begin
          stateNext = StIdle;
        end
      end
      default: stateNext = StIdle;
    endcase
  end

`ifdef PADDLE_ACCEL_EN
  localparam int unsigned     HoldW   = $clog2(2 * ACCEL_HOLD + 1);
  localparam logic [HoldW-1:0] HoldOne = HoldW'(ACCEL_HOLD);
  localparam logic [HoldW-1:0] HoldTwo = HoldW'(2 * ACCEL_HOLD);

  logic [HoldW-1:0] holdQ;
  logic [HoldW-1:0] holdNext;

  // Counts ticks spent in the same MOVE state; saturates once the step has reached 4.
  always_comb begin
    holdNext = '0;
    if (stateNext != StIdle && stateNext == stateQ) begin
      holdNext = (holdQ == HoldTwo) ? holdQ : holdQ + 1'b1;
    end
    if (holdNext < HoldOne) begin
      step = 3'd1;
    end else if (holdNext < HoldTwo) begin
      step = 3'd2;
    end else begin
      step = 3'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holdQ <= '0;
    end else if (tick) begin
      holdQ <= holdNext;
    end
  end
`else
  assign step = 3'd1;
`endif

  // Extra top bit catches overflow on the right and borrow on the left.
  always_comb begin
    posExt  = {1'b0, paddle_pos};
    stepExt = (POS_W + 1)'(step);
    sumR    = posExt + stepExt;
    diffL   = posExt - stepExt;
    newR    = (sumR > PosMaxExt) ? PosMaxExt[POS_W-1:0] : sumR[POS_W-1:0];
    newL    = diffL[POS_W] ? '0 : diffL[POS_W-1:0];
    unique case (stateNext)
      StMoveR: posNew = newR;
      StMoveL: posNew = newL;
      default: posNew = paddle_pos;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ     <= StIdle;
      paddle_pos <= POS_W'(POS_INIT);
      pos_update <= 1'b0;
    end else begin
      pos_update <= 1'b0;
      if (tick) begin
        stateQ     <= stateNext;
        paddle_pos <= posNew;
        pos_update <= (posNew != paddle_pos);
      end
    end
  end

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Self-checking bench for paddle_input_ctrl: cycle model plus directed literal checks.
// Build with PADDLE_ACCEL_EN defined to exercise the acceleration sequence.
module tb_paddle_input_ctrl;

  localparam int Deb   = 4;
  localparam int Tick  = 10;
  localparam int Hold  = 3;
  localparam int PMax  = 511;
  localparam int PInit = 256;

  logic       clk;
  logic       reset;
  logic       left_raw;
  logic       right_raw;
  logic [8:0] paddle_pos;
  logic       pos_update;
  logic       left_db;
  logic       right_db;

  int tests;
  int fails;
  int q[$];

  paddle_input_ctrl #(
    .POS_W      (9),
    .POS_MAX    (PMax),
    .POS_INIT   (PInit),
    .DEB_CYCLES (Deb),
    .TICK_CYCLES(Tick),
    .ACCEL_HOLD (Hold)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .left_raw  (left_raw),
    .right_raw (right_raw),
    .paddle_pos(paddle_pos),
    .pos_update(pos_update),
    .left_db   (left_db),
    .right_db  (right_db)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: positions as integers, buttons as sample histories and run lengths.
  int mPos, mUpd, mDbL, mDbR, mS1L, mS2L, mS1R, mS2R, mRunL, mRunR, mCyc;
  int mLastDir, mHold, mDir, mStep, mNext;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mPos = PInit; mUpd = 0; mDbL = 0; mDbR = 0;
      mS1L = 0; mS2L = 0; mS1R = 0; mS2R = 0;
      mRunL = 0; mRunR = 0; mCyc = 0; mLastDir = 0; mHold = 0;
    end else begin
      mUpd = 0;
      if (mCyc % Tick == Tick - 1) begin
        mDir = (mDbR != 0) ? 1 : ((mDbL != 0) ? -1 : 0);
        mHold = (mDir != 0 && mDir == mLastDir) ? mHold + 1 : 0;
        mLastDir = mDir;
`ifdef PADDLE_ACCEL_EN
        mStep = (mHold < Hold) ? 1 : ((mHold < 2 * Hold) ? 2 : 4);
`else
        mStep = 1;
`endif
        mNext = mPos + mDir * mStep;
        if (mNext < 0) mNext = 0;
        if (mNext > PMax) mNext = PMax;
        mUpd = (mNext != mPos) ? 1 : 0;
        mPos = mNext;
      end
      // A level is accepted after Deb consecutive disagreeing samples.
      if (mS2L != mDbL) begin
        mRunL++;
        if (mRunL == Deb) begin mDbL = mS2L; mRunL = 0; end
      end else mRunL = 0;
      if (mS2R != mDbR) begin
        mRunR++;
        if (mRunR == Deb) begin mDbR = mS2R; mRunR = 0; end
      end else mRunR = 0;
      mS2L = mS1L; mS1L = int'(left_raw);
      mS2R = mS1R; mS1R = int'(right_raw);
      mCyc++;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      tests++;
      if (int'(paddle_pos) != mPos || int'(pos_update) != mUpd ||
          int'(left_db) != mDbL || int'(right_db) != mDbR) begin
        fails++;
        $display("FAIL model t=%0t: pos=%0d upd=%0b ldb=%0b rdb=%0b, required pos=%0d upd=%0d ldb=%0d rdb=%0d",
                 $time, paddle_pos, pos_update, left_db, right_db, mPos, mUpd, mDbL, mDbR);
      end
      if (pos_update) q.push_back(int'(paddle_pos));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic int pulseAt(input int idx);
    if (idx < 0 || idx >= q.size()) return -1;
    return q[idx];
  endfunction

  task automatic setRaw(input logic l, input logic r);
    @(negedge clk);
    #1;
    left_raw  = l;
    right_raw = r;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic waitPulses(input int n, input int budget, input string name);
    int base = q.size();
    int k = 0;
    while (q.size() < base + n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (q.size() < base + n) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: got %0d pulses, required %0d", name, q.size() - base, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  int base;
  int k;
  int lastSize;
  int exp8[8];
  int tail3[3];
  int tailL;

  initial begin
    tests = 0;
    fails = 0;
`ifdef PADDLE_ACCEL_EN
    exp8  = '{257, 258, 259, 261, 263, 265, 269, 273};
    tail3 = '{505, 509, 511};
    tailL = 2;
`else
    exp8  = '{257, 258, 259, 260, 261, 262, 263, 264};
    tail3 = '{509, 510, 511};
    tailL = 1;
`endif
    left_raw  = 1'b0;
    right_raw = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    check("reset pos", int'(paddle_pos), 256);
    check("reset upd", int'(pos_update), 0);

    // Bounce: 2-cycle pulses never survive a 4-cycle debounce.
    for (int i = 0; i < 20; i++) begin
      setRaw(1'b0, (i % 2) == 0);
      @(negedge clk);
    end
    setRaw(1'b0, 1'b0);
    waitCycles(30);
    check("bounce rdb", int'(right_db), 0);
    check("bounce pos", int'(paddle_pos), 256);
    check("bounce pulses", q.size(), 0);

    // Hold right: five steps from 256.
    setRaw(1'b0, 1'b1);
    waitPulses(5, 200, "hold right");
    for (int i = 0; i < 5; i++) check("hold right step", pulseAt(i), exp8[i]);

    // Keep holding to the upper limit.
    waitCycles(2700);
    check("sat high pos", int'(paddle_pos), 511);
    for (int i = 0; i < 3; i++) check("sat high tail", pulseAt(q.size() - 3 + i), tail3[i]);
    lastSize = q.size();
    waitCycles(100);
    check("sat high quiet", q.size(), lastSize);

    // Left to the lower limit.
    setRaw(1'b1, 1'b0);
    waitCycles(5400);
    check("sat low pos", int'(paddle_pos), 0);
    check("sat low tail1", pulseAt(q.size() - 2), tailL);
    check("sat low tail0", pulseAt(q.size() - 1), 0);
    lastSize = q.size();
    waitCycles(100);
    check("sat low quiet", q.size(), lastSize);

    // Both held: right wins; dropping right then moves left.
    setRaw(1'b0, 1'b0);
    waitCycles(30);
    base = q.size();
    setRaw(1'b1, 1'b1);
    waitPulses(3, 100, "both held");
    for (int i = 0; i < 3; i++) check("both right", pulseAt(base + i), i + 1);
    setRaw(1'b1, 1'b0);
    waitPulses(1, 40, "release right");
    check("left after release", pulseAt(base + 3), 2);

    // Async reset while moving right.
    setRaw(1'b0, 1'b1);
    waitPulses(5, 200, "pre-reset move");
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async reset pos", int'(paddle_pos), 256);
    check("async reset upd", int'(pos_update), 0);
    check("async reset rdb", int'(right_db), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    base = q.size();
    k = 0;
    while (q.size() == base && k < 30) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("first move latency", k, 10);
    check("first move value", pulseAt(base), 257);

    waitPulses(7, 300, "post-reset run");
    for (int i = 0; i < 8; i++) check("run sequence", pulseAt(base + i), exp8[i]);
    setRaw(1'b1, 1'b0);
    waitPulses(1, 40, "direction change");
    check("direction change step", pulseAt(base + 8), exp8[7] - 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
